etapa_if: RTL and testbench
===========================

ETAPA_IF -- requirements
Module: etapa_if

Interface
REQ-001 The block SHALL take parameter NBITS, default 32, as the width of PC, addresses and instruction words.
REQ-002 The block SHALL take parameter IMEM_DEPTH, default 256, as the number of instruction words held, a power of two.
REQ-003 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 i_reset  in  1  reset, synchronous and active-high.
REQ-005 i_PC_Write  in  1  hazard-unit enable; 0 = stall the PC and the IF/ID register.
REQ-006 i_Branch_Taken  in  1 and i_Branch_Target  in  NBITS  resolved branch redirect.
REQ-007 i_Jump  in  1 and i_Jump_Target  in  NBITS  jump redirect.
REQ-008 i_Run  in  1  one-cycle pulse starting free-running execution.
REQ-009 i_IMem_We  in  1, i_IMem_Addr  in  NBITS (byte address), i_IMem_Data  in  NBITS  program loader write port.
REQ-010 o_PC, o_PC4, o_PC8, o_Instruction  out  NBITS each  values captured by the IF/ID register.
REQ-011 o_IF_ID_Write  out  1  enable for the IF/ID register; o_Flush  out  1  IF/ID flush request; o_Halted  out  1  halt reached.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and HALTED, plus STEP when REQ-030 applies.
REQ-013 IDLE: PC held, o_IF_ID_Write=0; i_Run moves to RUN next cycle.
REQ-014 o_PC4 SHALL be o_PC+4 and o_PC8 SHALL be o_PC+8, modulo 2^NBITS, combinational from the PC register.
REQ-015 o_Instruction SHALL be the word at index o_PC[log2(IMEM_DEPTH)+1:2], combinational read, zero latency; PC bits [1:0] ignored; higher bits wrap.
REQ-016 In RUN, next PC priority SHALL be: i_Branch_Taken -> i_Branch_Target; else i_Jump -> i_Jump_Target; else i_PC_Write=1 -> PC+4; else hold.
REQ-017 A redirect SHALL update PC even when i_PC_Write=0 in the same cycle.
REQ-018 In RUN, o_IF_ID_Write SHALL equal i_PC_Write, and o_Flush SHALL equal i_Branch_Taken OR i_Jump.
REQ-019 When in RUN o_Instruction equals HALT_WORD (32'hFFFF_FFFF), i_PC_Write=1 and no redirect is active, PC SHALL hold and the FSM SHALL enter HALTED next cycle; the halt word itself is passed to IF/ID that cycle.
REQ-020 A redirect in the same cycle as a halt word SHALL take priority; no halt occurs.
REQ-021 HALTED: PC held, o_Instruction forced to NOP_WORD (0), o_IF_ID_Write=1 so the pipeline drains, o_Flush=0, o_Halted=1; i_Run ignored; only reset exits.
REQ-022 Loader writes SHALL be accepted only in IDLE; ignored in every other state.
REQ-023 A write to the word currently addressed by PC SHALL appear on o_Instruction in the following cycle.
REQ-024 i_Run in any state other than IDLE or STEP SHALL be ignored.

Reset
REQ-025 On i_reset high at a clock edge: PC=0, state=IDLE, o_IF_ID_Write=0, o_Flush=0, o_Halted=0, regardless of state, including mid-RUN or mid-redirect.
REQ-026 Reset SHALL NOT clear instruction memory contents.
REQ-027 Reset SHALL have priority over every other input, including loader writes in the same cycle.

Configuration
REQ-028 Macro ETAPA_IF_STEP_EN SHALL compile in single-step debug support.
REQ-029 Without ETAPA_IF_STEP_EN: no i_Step port, no STEP state; behaviour as REQ-012..REQ-027.
REQ-030 With ETAPA_IF_STEP_EN: port i_Step  in  1. An i_Step pulse in IDLE or STEP SHALL perform exactly one RUN-equivalent cycle (REQ-016..REQ-019) and then be in STEP. STEP holds PC with o_IF_ID_Write=0. i_Run in STEP enters RUN. A halt word during a step enters HALTED.

Structure
REQ-031 Shared package mips_pkg SHALL hold HALT_WORD, NOP_WORD and the FSM state encoding.
REQ-032 Instruction storage SHALL be sub-module memoria_instrucciones (one sync write port, one async read port); PC, next-PC logic and FSM stay in etapa_if.

Verification
REQ-033 Reset, load words 0..3, pulse i_Run -> o_PC 0,4,8,12 on successive cycles; o_PC8 = o_PC+8; o_IF_ID_Write=1.
REQ-034 In RUN at PC=8: i_PC_Write=0 for 2 cycles -> PC holds 8, o_IF_ID_Write=0; on release -> PC=12.
REQ-035 At PC=8: i_PC_Write=0, i_Branch_Taken=1, target 0x40, i_Jump=1, target 0x80 -> PC=0x40 next cycle, o_Flush=1.
REQ-036 Word 5 = 32'hFFFF_FFFF -> PC holds 0x14; o_Halted=1 and o_Instruction=0 from the next cycle; i_Run then -> no change; i_reset -> PC=0, IDLE.
REQ-037 Loader write during RUN -> memory unchanged; reset asserted mid-RUN at PC=0x1C -> PC=0, memory intact.
REQ-038 With ETAPA_IF_STEP_EN: three i_Step pulses from IDLE -> PC 4, 8, 12, one o_IF_ID_Write cycle each; i_Run -> free-running.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and FSM state encoding for the instruction-fetch stage.
// STEP state exists only when ETAPA_IF_STEP_EN is defined.
package mips_pkg;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
`ifdef ETAPA_IF_STEP_EN
        ,
        StStep   = 2'd3
`endif
    } if_state_e;

endpackage

// File: rtl/memoria_instrucciones.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
// Contents are never reset.
module memoria_instrucciones #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 256,
    localparam int unsigned AddrW = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/etapa_if.sv
// Instruction-fetch stage: PC register, next-PC selection, run/halt FSM and program loader.
// Define ETAPA_IF_STEP_EN to add the i_Step single-step debug port and STEP state.
module etapa_if
    import mips_pkg::*;
#(
    parameter int unsigned NBITS      = 32,
    parameter int unsigned IMEM_DEPTH = 256
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_PC_Write,
    input  logic             i_Branch_Taken,
    input  logic [NBITS-1:0] i_Branch_Target,
    input  logic             i_Jump,
    input  logic [NBITS-1:0] i_Jump_Target,
    input  logic             i_Run,
`ifdef ETAPA_IF_STEP_EN
    input  logic             i_Step,
`endif
    input  logic             i_IMem_We,
    input  logic [NBITS-1:0] i_IMem_Addr,
    input  logic [NBITS-1:0] i_IMem_Data,
    output logic [NBITS-1:0] o_PC,
    output logic [NBITS-1:0] o_PC4,
    output logic [NBITS-1:0] o_PC8,
    output logic [NBITS-1:0] o_Instruction,
    output logic             o_IF_ID_Write,
    output logic             o_Flush,
    output logic             o_Halted
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    if_state_e        state_q, state_d;
    logic [NBITS-1:0] pc_q, pc_d;
    logic [NBITS-1:0] instr_raw;
    logic             exec;
    logic             imem_we;

    // Address bits outside the word index are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^{i_IMem_Addr[NBITS-1:AW+2], i_IMem_Addr[1:0]};

    assign imem_we = i_IMem_We && (state_q == StIdle) && !i_reset;

    memoria_instrucciones #(
        .Width (NBITS),
        .Depth (IMEM_DEPTH)
    ) u_imem (
        .clk_i   (i_clk),
        .we_i    (imem_we),
        .waddr_i (i_IMem_Addr[AW+1:2]),
        .wdata_i (i_IMem_Data),
        .raddr_i (pc_q[AW+1:2]),
        .rdata_o (instr_raw)
    );

    always_comb begin
        pc_d          = pc_q;
        state_d       = state_q;
        exec          = 1'b0;
        o_IF_ID_Write = 1'b0;
        o_Flush       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_Run) begin
                    state_d = StRun;
`ifdef ETAPA_IF_STEP_EN
                end else if (i_Step) begin
                    exec    = 1'b1;
                    state_d = StStep;
`endif
                end
            end
            StRun: exec = 1'b1;
`ifdef ETAPA_IF_STEP_EN
            StStep: begin
                if (i_Run) begin
                    state_d = StRun;
                end else if (i_Step) begin
                    exec = 1'b1;
                end
            end
`endif
            StHalted: o_IF_ID_Write = 1'b1;
            default:  state_d = StIdle;
        endcase

        // One RUN-equivalent cycle: redirects win over stalls and over a halt word.
        if (exec) begin
            o_IF_ID_Write = i_PC_Write;
            o_Flush       = i_Branch_Taken || i_Jump;
            if (i_Branch_Taken) begin
                pc_d = i_Branch_Target;
            end else if (i_Jump) begin
                pc_d = i_Jump_Target;
            end else if (i_PC_Write) begin
                if (instr_raw == NBITS'(HALT_WORD)) begin
                    state_d = StHalted;
                end else begin
                    pc_d = pc_q + NBITS'(4);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q    <= '0;
            state_q <= StIdle;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    assign o_PC          = pc_q;
    assign o_PC4         = pc_q + NBITS'(4);
    assign o_PC8         = pc_q + NBITS'(8);
    assign o_Halted      = (state_q == StHalted);
    assign o_Instruction = (state_q == StHalted) ? NBITS'(NOP_WORD) : instr_raw;

endmodule

// File: tb/tb_etapa_if.sv
// Directed bench for etapa_if: table-driven RUN vectors plus reset, loader and step sequences.
// Step checks are compiled in when ETAPA_IF_STEP_EN is defined.
module tb_etapa_if;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_PC_Write;
    logic        i_Branch_Taken;
    logic [31:0] i_Branch_Target;
    logic        i_Jump;
    logic [31:0] i_Jump_Target;
    logic        i_Run;
`ifdef ETAPA_IF_STEP_EN
    logic        i_Step;
`endif
    logic        i_IMem_We;
    logic [31:0] i_IMem_Addr;
    logic [31:0] i_IMem_Data;
    logic [31:0] o_PC, o_PC4, o_PC8, o_Instruction;
    logic        o_IF_ID_Write, o_Flush, o_Halted;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    etapa_if #(
        .NBITS      (32),
        .IMEM_DEPTH (256)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_PC_Write      (i_PC_Write),
        .i_Branch_Taken  (i_Branch_Taken),
        .i_Branch_Target (i_Branch_Target),
        .i_Jump          (i_Jump),
        .i_Jump_Target   (i_Jump_Target),
        .i_Run           (i_Run),
`ifdef ETAPA_IF_STEP_EN
        .i_Step          (i_Step),
`endif
        .i_IMem_We       (i_IMem_We),
        .i_IMem_Addr     (i_IMem_Addr),
        .i_IMem_Data     (i_IMem_Data),
        .o_PC            (o_PC),
        .o_PC4           (o_PC4),
        .o_PC8           (o_PC8),
        .o_Instruction   (o_Instruction),
        .o_IF_ID_Write   (o_IF_ID_Write),
        .o_Flush         (o_Flush),
        .o_Halted        (o_Halted)
    );

    typedef struct {
        logic        pw;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        run;
        logic [31:0] e_pc;
        logic        e_ifw;
        logic        e_fl;
        logic        e_halt;
        logic [31:0] e_ins;
    } vec_t;

    vec_t vecs[16];

    function automatic logic [31:0] word(input int idx);
        if (idx == 5) return 32'hFFFF_FFFF;
        return 32'hA000_0000 + 32'(idx);
    endfunction

    function automatic vec_t mk(input logic pw, input logic br, input logic [31:0] bt,
                                input logic jmp, input logic [31:0] jt, input logic run,
                                input logic [31:0] e_pc, input logic e_ifw, input logic e_fl,
                                input logic e_halt, input logic [31:0] e_ins);
        vec_t v;
        v.pw = pw; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt; v.run = run;
        v.e_pc = e_pc; v.e_ifw = e_ifw; v.e_fl = e_fl; v.e_halt = e_halt; v.e_ins = e_ins;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_in();
        i_PC_Write = 1'b0; i_Branch_Taken = 1'b0; i_Branch_Target = '0;
        i_Jump = 1'b0; i_Jump_Target = '0; i_Run = 1'b0;
        i_IMem_We = 1'b0; i_IMem_Addr = '0; i_IMem_Data = '0;
`ifdef ETAPA_IF_STEP_EN
        i_Step = 1'b0;
`endif
    endtask

    task automatic load(input int idx, input logic [31:0] data);
        i_IMem_We = 1'b1; i_IMem_Addr = 32'(idx) * 4; i_IMem_Data = data;
        tick();
        i_IMem_We = 1'b0;
    endtask

    task automatic chk_state(input string nm, input logic [31:0] pc, input logic ifw,
                             input logic fl, input logic halt);
        @(negedge i_clk);
        chk({nm, ".pc"},   o_PC, pc);
        chk({nm, ".pc8"},  o_PC8, pc + 32'd8);
        chk({nm, ".ifw"},  {31'b0, o_IF_ID_Write}, {31'b0, ifw});
        chk({nm, ".fl"},   {31'b0, o_Flush}, {31'b0, fl});
        chk({nm, ".halt"}, {31'b0, o_Halted}, {31'b0, halt});
    endtask

    initial begin
        clear_in();
        i_reset = 1'b1;
        tick();
        tick();
        i_reset = 1'b0;
        chk_state("reset", 32'h0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) load(i, word(i));
        load(16, word(16));
        @(negedge i_clk);
        chk("load.w0", o_Instruction, word(0));

        vecs[0]  = mk(1, 0, 0,     0, 0,     0, 32'h00, 1, 0, 0, word(0));
        vecs[1]  = mk(1, 0, 0,     0, 0,     0, 32'h04, 1, 0, 0, word(1));
        vecs[2]  = mk(0, 0, 0,     0, 0,     0, 32'h08, 0, 0, 0, word(2));
        vecs[3]  = mk(0, 0, 0,     0, 0,     0, 32'h08, 0, 0, 0, word(2));
        vecs[4]  = mk(1, 0, 0,     0, 0,     0, 32'h08, 1, 0, 0, word(2));
        vecs[5]  = mk(1, 0, 0,     1, 32'h08, 0, 32'h0C, 1, 1, 0, word(3));
        vecs[6]  = mk(0, 1, 32'h40, 1, 32'h80, 0, 32'h08, 0, 1, 0, word(2));
        vecs[7]  = mk(1, 0, 0,     1, 32'h0C, 0, 32'h40, 1, 1, 0, word(16));
        vecs[8]  = mk(1, 0, 0,     0, 0,     0, 32'h0C, 1, 0, 0, word(3));
        vecs[9]  = mk(1, 0, 0,     0, 0,     0, 32'h10, 1, 0, 0, word(4));
        vecs[10] = mk(1, 1, 32'h18, 0, 0,     0, 32'h14, 1, 1, 0, 32'hFFFF_FFFF);
        vecs[11] = mk(1, 0, 0,     1, 32'h14, 0, 32'h18, 1, 1, 0, word(6));
        vecs[12] = mk(0, 0, 0,     0, 0,     0, 32'h14, 0, 0, 0, 32'hFFFF_FFFF);
        vecs[13] = mk(1, 0, 0,     0, 0,     0, 32'h14, 1, 0, 0, 32'hFFFF_FFFF);
        vecs[14] = mk(1, 1, 32'h40, 1, 32'h80, 1, 32'h14, 1, 0, 1, 32'h0);
        vecs[15] = mk(1, 0, 0,     0, 0,     1, 32'h14, 1, 0, 1, 32'h0);

        i_Run = 1'b1;
        chk_state("idle_run", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        i_Run = 1'b0;

        for (int i = 0; i < 16; i++) begin
            i_PC_Write = vecs[i].pw; i_Branch_Taken = vecs[i].br; i_Branch_Target = vecs[i].bt;
            i_Jump = vecs[i].jmp; i_Jump_Target = vecs[i].jt; i_Run = vecs[i].run;
            chk_state($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_ifw, vecs[i].e_fl,
                      vecs[i].e_halt);
            chk($sformatf("v%0d.ins", i), o_Instruction, vecs[i].e_ins);
            chk($sformatf("v%0d.pc4", i), o_PC4, vecs[i].e_pc + 32'd4);
            tick();
        end
        clear_in();

        // Reset out of HALTED; memory must survive.
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk_state("rst_halt", 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_halt.ins", o_Instruction, word(0));

        // Loader write during RUN is ignored; reset mid-RUN beats a loader write.
        i_Run = 1'b1;
        tick();
        i_Run = 1'b0;
        i_PC_Write = 1'b1;
        i_IMem_We = 1'b1; i_IMem_Addr = 32'h4; i_IMem_Data = 32'hDEAD_BEEF;
        tick();
        i_IMem_We = 1'b0;
        @(negedge i_clk);
        chk("runwr.pc", o_PC, 32'h4);
        chk("runwr.ins", o_Instruction, word(1));
        i_Jump = 1'b1; i_Jump_Target = 32'h1C;
        tick();
        i_Jump = 1'b0;
        @(negedge i_clk);
        chk("j1c.pc", o_PC, 32'h1C);
        chk("j1c.ins", o_Instruction, word(7));
        i_reset = 1'b1;
        i_IMem_We = 1'b1; i_IMem_Addr = 32'h0; i_IMem_Data = 32'h1234_5678;
        tick();
        i_reset = 1'b0;
        i_IMem_We = 1'b0;
        chk_state("rst_run", 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_run.ins", o_Instruction, word(0));

        // IDLE holds PC; write to the addressed word shows up next cycle.
        i_PC_Write = 1'b1;
        tick();
        chk_state("idle_hold", 32'h0, 1'b0, 1'b0, 1'b0);
        i_PC_Write = 1'b0;
        load(0, 32'h5555_AAAA);
        @(negedge i_clk);
        chk("wr_pc.ins", o_Instruction, 32'h5555_AAAA);

`ifdef ETAPA_IF_STEP_EN
        i_PC_Write = 1'b1;
        for (int s = 0; s < 3; s++) begin
            i_Step = 1'b1;
            chk_state($sformatf("step%0d", s), 32'(s) * 4, 1'b1, 1'b0, 1'b0);
            tick();
            i_Step = 1'b0;
            chk_state($sformatf("stepwait%0d", s), 32'(s + 1) * 4, 1'b0, 1'b0, 1'b0);
            tick();
        end
        i_Run = 1'b1;
        chk_state("step_run", 32'h0C, 1'b0, 1'b0, 1'b0);
        tick();
        i_Run = 1'b0;
        chk_state("free0", 32'h0C, 1'b1, 1'b0, 1'b0);
        tick();
        chk_state("free1", 32'h10, 1'b1, 1'b0, 1'b0);
        clear_in();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
